// File: rtl/conv1d_engine_if.sv
`default_nettype none
// ------------------------------------------------------------------
// conv1d_engine_if : SRAM-side bus between the conv1d engine and the memory mux
// Rev 1.0
// ------------------------------------------------------------------
interface conv1d_engine_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 7
);
  logic                 ext_gnt;
  logic                 mem_req;
  logic                 mem_we;
  logic [AddrWidth-1:0] mem_addr;
  logic [DataWidth-1:0] mem_wdata;
  logic [3:0]           mem_be;
  logic [DataWidth-1:0] mem_rdata;

  modport master (
    output ext_gnt, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata
  );

  modport slave (
    input  ext_gnt, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/conv1d_engine.sv
`default_nettype none
// ------------------------------------------------------------------
// conv1d_engine : sequential-MAC valid-mode 1-D convolution over a single-port SRAM
// Rev 1.0
// ------------------------------------------------------------------
module conv1d_engine #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 7,
  parameter int MaxTaps   = 8
) (
  input  wire                  clk_i,
  input  wire                  rst_ni,
  input  wire                  start_i,
  input  wire  [AddrWidth-1:0] in_len_i,
  input  wire  [3:0]           k_len_i,
  input  wire  [AddrWidth-1:0] in_base_i,
  input  wire  [AddrWidth-1:0] k_base_i,
  input  wire  [AddrWidth-1:0] out_base_i,
  input  wire  [4:0]           shift_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  conv1d_engine_if.master      mem
);

  localparam int AccWidth = 2 * DataWidth;
  localparam int TapIdxW  = $clog2(MaxTaps);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDK  = 3'd1,
    S_MAC  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e                      state_q;
  logic [AddrWidth-1:0]        n_q, in_base_q, k_base_q, out_base_q, i_q;
  logic [3:0]                  k_q, cnt_q;
  logic [4:0]                  shift_q;
  logic signed [AccWidth-1:0]  acc_q;
  logic [DataWidth-1:0]        taps_q [MaxTaps];
  logic                        tap_vld_q;
  logic [TapIdxW-1:0]          tap_idx_q;
  logic                        rd_vld_q;
  logic                        busy_q, done_q, err_q, gnt_q, req_q, we_q;
  logic [AddrWidth-1:0]        addr_q;
  logic [3:0]                  be_q;

  function automatic logic signed [AccWidth-1:0] sext(input logic [DataWidth-1:0] v);
    return AccWidth'($signed(v));
  endfunction

  logic                       cfg_ok;
  logic [AddrWidth-1:0]       k_ext_i, k_ext_q;
  logic                       last_tap, last_out;
  logic [TapIdxW-1:0]         mac_idx, last_idx;
  logic signed [AccWidth-1:0] mac_prod, wr_prod, acc_d, wr_sum;

  assign k_ext_i  = AddrWidth'(k_len_i);
  assign k_ext_q  = AddrWidth'(k_q);
  assign cfg_ok   = (k_len_i != 4'd0) && (32'(k_len_i) <= MaxTaps) && (k_ext_i <= in_len_i);
  assign last_tap = (cnt_q == k_q - 4'd1);
  assign last_out = (i_q == n_q - k_ext_q);

  // Each x read lands one cycle later, so it pairs with the tap of the previous slot.
  assign mac_idx  = TapIdxW'(cnt_q - 4'd1);
  assign last_idx = TapIdxW'(k_q - 4'd1);
  assign mac_prod = sext(mem.mem_rdata) * sext(taps_q[mac_idx]);
  assign wr_prod  = sext(mem.mem_rdata) * sext(taps_q[last_idx]);
  assign acc_d    = rd_vld_q ? acc_q + mac_prod : acc_q;
  assign wr_sum   = acc_q + wr_prod;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      in_base_q  <= '0;
      k_base_q   <= '0;
      out_base_q <= '0;
      i_q        <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      acc_q      <= '0;
      tap_vld_q  <= 1'b0;
      tap_idx_q  <= '0;
      rd_vld_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      gnt_q      <= 1'b1;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      for (int t = 0; t < MaxTaps; t++) taps_q[t] <= '0;
    end else begin
      tap_vld_q <= 1'b0;
      done_q    <= 1'b0;
      if (tap_vld_q) taps_q[tap_idx_q] <= mem.mem_rdata;

      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            n_q        <= in_len_i;
            k_q        <= k_len_i;
            in_base_q  <= in_base_i;
            k_base_q   <= k_base_i;
            out_base_q <= out_base_i;
            shift_q    <= shift_i;
            err_q      <= !cfg_ok;
            busy_q     <= 1'b1;
            gnt_q      <= 1'b0;
            cnt_q      <= '0;
            if (cfg_ok) begin
              state_q <= S_LDK;
              req_q   <= 1'b1;
              be_q    <= 4'hF;
              addr_q  <= k_base_i;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end

        S_LDK: begin
          tap_vld_q <= 1'b1;
          tap_idx_q <= TapIdxW'(cnt_q);
          if (last_tap) begin
            state_q  <= S_MAC;
            cnt_q    <= '0;
            i_q      <= '0;
            acc_q    <= '0;
            rd_vld_q <= 1'b0;
            addr_q   <= in_base_q;
          end else begin
            cnt_q  <= cnt_q + 4'd1;
            addr_q <= k_base_q + AddrWidth'(cnt_q) + AddrWidth'(1);
          end
        end

        S_MAC: begin
          acc_q    <= acc_d;
          rd_vld_q <= 1'b1;
          if (last_tap) begin
            state_q <= S_WR;
            we_q    <= 1'b1;
            addr_q  <= out_base_q + i_q;
          end else begin
            cnt_q  <= cnt_q + 4'd1;
            addr_q <= in_base_q + i_q + AddrWidth'(cnt_q) + AddrWidth'(1);
          end
        end

        S_WR: begin
          acc_q    <= '0;
          rd_vld_q <= 1'b0;
          we_q     <= 1'b0;
          cnt_q    <= '0;
          if (last_out) begin
            state_q <= S_DONE;
            req_q   <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_MAC;
            i_q     <= i_q + AddrWidth'(1);
            addr_q  <= in_base_q + i_q + AddrWidth'(1);
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          gnt_q   <= 1'b1;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign mem.ext_gnt   = gnt_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  // Write data depends on the read returning in the WR cycle itself, so it cannot be registered.
  assign mem.mem_wdata = (state_q == S_WR) ? DataWidth'(wr_sum >>> shift_q) : '0;

endmodule
`default_nettype wire

// File: tb/tb_conv1d_engine.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_conv1d_engine : scoreboard bench for conv1d_engine with an SRAM model and reference convolution
// Rev 1.0
// ------------------------------------------------------------------
module tb_conv1d_engine;
  localparam int DW = 32;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] in_len = '0, in_base = '0, k_base = '0, out_base = '0;
  logic [3:0]    k_len = '0;
  logic [4:0]    shift = '0;
  logic          busy, done, err;

  logic          ext_req = 1'b0, ext_we = 1'b0;
  logic [AW-1:0] ext_addr = '0;
  logic [DW-1:0] ext_wdata = '0;
  logic [DW-1:0] sram [128];

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } acc_t;
  acc_t exp_q[$];
  acc_t mon_e;

  int xv[128];
  int hv[16];

  conv1d_engine_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();

  conv1d_engine #(.DataWidth(DW), .AddrWidth(AW), .MaxTaps(8)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .in_len_i  (in_len),
    .k_len_i   (k_len),
    .in_base_i (in_base),
    .k_base_i  (k_base),
    .out_base_i(out_base),
    .shift_i   (shift),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err),
    .mem       (bus)
  );

  always #5 clk = ~clk;

  // SRAM with the external/engine mux selected by ext_gnt
  always @(posedge clk) begin
    if (bus.ext_gnt) begin
      if (ext_req) begin
        if (ext_we) sram[ext_addr] <= ext_wdata;
        bus.mem_rdata <= sram[ext_addr];
      end
    end else if (bus.mem_req) begin
      if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= sram[bus.mem_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, expv);
    end
  endtask

  task automatic check_mem(input string name, input int a, input int expv);
    logic [31:0] e;
    e = expv;
    check(name, {32'd0, sram[7'(a)]}, {32'd0, e});
  endtask

  // Monitor: every engine access must match the next expected access.
  always @(negedge clk) begin
    if (rst_n && bus.mem_req) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_access: got addr=%0d we=%0b want=no access", bus.mem_addr, bus.mem_we);
      end else begin
        mon_e = exp_q.pop_front();
        check("acc_we", 64'(bus.mem_we), 64'(mon_e.we));
        check("acc_addr", 64'(bus.mem_addr), 64'(mon_e.addr));
        check("acc_gnt", 64'(bus.ext_gnt), 64'(0));
        if (mon_e.we) begin
          check("acc_wdata", 64'(bus.mem_wdata), 64'(mon_e.data));
          check("acc_be", 64'(bus.mem_be), 64'(4'hF));
        end
      end
    end
  end

  task automatic write_word(input int a, input int d);
    @(negedge clk);
    ext_req   = 1'b1;
    ext_we    = 1'b1;
    ext_addr  = 7'(a);
    ext_wdata = d;
    @(posedge clk);
    #1;
    ext_req = 1'b0;
    ext_we  = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_err"}, 64'(err), 64'(0));
    check({tag, "_gnt"}, 64'(bus.ext_gnt), 64'(1));
    check({tag, "_req"}, 64'(bus.mem_req), 64'(0));
    check({tag, "_we"}, 64'(bus.mem_we), 64'(0));
    check({tag, "_addr"}, 64'(bus.mem_addr), 64'(0));
    check({tag, "_wdata"}, 64'(bus.mem_wdata), 64'(0));
    check({tag, "_be"}, 64'(bus.mem_be), 64'(0));
  endtask

  // Loads operands through the external port and queues the expected access stream.
  task automatic prepare(input int n, input int k, input int inb, input int kb, input int outb,
                         input int sh, output bit valid, output int cycles);
    int     m;
    longint acc;
    valid  = (k >= 1) && (k <= 8) && (k <= n);
    cycles = 1;
    if (valid) begin
      m = n - k + 1;
      for (int j = 0; j < k; j++) write_word(kb + j, hv[j]);
      for (int i = 0; i < n; i++) write_word(inb + i, xv[i]);
      for (int c = 0; c < k; c++) exp_q.push_back('{1'b0, 7'(kb + c), 32'd0});
      for (int i = 0; i < m; i++) begin
        acc = 0;
        for (int j = 0; j < k; j++) begin
          exp_q.push_back('{1'b0, 7'(inb + i + j), 32'd0});
          acc += longint'(xv[i + j]) * longint'(hv[j]);
        end
        acc = acc >>> sh;
        exp_q.push_back('{1'b1, 7'(outb + i), 32'(acc)});
      end
      cycles = k + m * (k + 1) + 1;
    end
  endtask

  task automatic launch(input int n, input int k, input int inb, input int kb, input int outb, input int sh);
    @(negedge clk);
    start    = 1'b1;
    in_len   = 7'(n);
    k_len    = 4'(k);
    in_base  = 7'(inb);
    k_base   = 7'(kb);
    out_base = 7'(outb);
    shift    = 5'(sh);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run(input string tag, input int n, input int k, input int inb, input int kb,
                     input int outb, input int sh, input bit poke);
    bit valid;
    int exp_cyc;
    int done_cyc, busy_cnt, gnt_low, req_cnt;
    done_cyc = -1;
    busy_cnt = 0;
    gnt_low  = 0;
    req_cnt  = 0;
    prepare(n, k, inb, kb, outb, sh, valid, exp_cyc);
    launch(n, k, inb, kb, outb, sh);
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      busy_cnt += int'(busy);
      gnt_low  += int'(!bus.ext_gnt);
      req_cnt  += int'(bus.mem_req);
      if (cyc == 1) check({tag, "_err_flag"}, 64'(err), 64'(!valid));
      start = poke && (cyc == 4);
      if (start) begin
        in_len = 7'($urandom);
        k_len  = 4'($urandom);
        k_base = 7'($urandom);
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check({tag, "_done_latency"}, 64'(done_cyc), 64'(exp_cyc));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_cyc));
    check({tag, "_gnt_low_cycles"}, 64'(gnt_low), 64'(exp_cyc));
    check({tag, "_err_at_done"}, 64'(err), 64'(!valid));
    if (!valid) check({tag, "_req_count"}, 64'(req_cnt), 64'(0));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 64'(done), 64'(0));
    check({tag, "_busy_after"}, 64'(busy), 64'(0));
    check({tag, "_gnt_after"}, 64'(bus.ext_gnt), 64'(1));
    check({tag, "_pending_access"}, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit vtmp;
    int ctmp, req_cnt;
    int rk, rn, rkb, rinb, routb, rsh;

    repeat (2) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;

    hv[0] = 1; hv[1] = 2; hv[2] = 3;
    for (int i = 0; i < 5; i++) xv[i] = i + 1;
    run("t1", 5, 3, 48, 40, 60, 0, 1'b1);
    check_mem("t1_y0", 60, 14);
    check_mem("t1_y1", 61, 20);
    check_mem("t1_y2", 62, 26);

    hv[0] = -1;
    xv[0] = 4; xv[1] = -8; xv[2] = 12; xv[3] = 100;
    run("t2", 4, 1, 20, 10, 30, 2, 1'b0);
    check_mem("t2_y0", 30, -1);
    check_mem("t2_y1", 31, 2);
    check_mem("t2_y2", 32, -3);
    check_mem("t2_y3", 33, -25);

    run("inv_k0", 5, 0, 0, 40, 60, 0, 1'b0);
    run("inv_k9", 10, 9, 0, 40, 60, 0, 1'b0);
    run("inv_k6", 5, 6, 0, 40, 60, 0, 1'b0);

    hv[0] = 1; hv[1] = 2; hv[2] = 3;
    for (int i = 0; i < 5; i++) xv[i] = i + 1;
    run("inplace", 5, 3, 0, 40, 0, 0, 1'b0);
    check_mem("inplace_m0", 0, 14);
    check_mem("inplace_m1", 1, 20);
    check_mem("inplace_m2", 2, 26);
    check_mem("inplace_m3", 3, 4);
    check_mem("inplace_m4", 4, 5);

    hv[0] = int'($urandom_range(0, 200)) - 100;
    hv[1] = int'($urandom_range(0, 200)) - 100;
    for (int i = 0; i < 4; i++) xv[i] = int'($urandom_range(0, 2000)) - 1000;
    run("wrap", 4, 2, 126, 10, 20, 1, 1'b0);

    // Reset in the middle of output 1's MAC phase
    hv[0] = 1; hv[1] = 2; hv[2] = 3;
    for (int i = 0; i < 5; i++) xv[i] = i + 1;
    write_word(61, 32'h0BAD_F00D);
    prepare(5, 3, 48, 40, 60, 0, vtmp, ctmp);
    launch(5, 3, 48, 40, 60, 0);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    req_cnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      req_cnt += int'(bus.mem_req);
    end
    check("midrst_req_count", 64'(req_cnt), 64'(0));
    check_mem("midrst_y0_written", 60, 14);
    check_mem("midrst_y1_untouched", 61, 32'h0BAD_F00D);

    for (int it = 0; it < 10; it++) begin
      rk    = int'($urandom_range(1, 8));
      rn    = int'($urandom_range(rk, 30));
      rkb   = int'($urandom_range(0, 127));
      rinb  = (rkb + 8) % 128;
      routb = (it % 2 == 1) ? rinb : (rinb + rn) % 128;
      rsh   = int'($urandom_range(0, 31));
      for (int j = 0; j < rk; j++)
        hv[j] = (it < 5) ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
      for (int i = 0; i < rn; i++)
        xv[i] = (it < 5) ? int'($urandom) : int'($urandom_range(0, 2000)) - 1000;
      run($sformatf("rand%0d", it), rn, rk, rinb, rkb, routb, rsh, it[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
